// File: rtl/layer_pkg.sv
// Shared types and sizing helpers for the fully connected layer.
package layer_pkg;

  typedef enum logic {
    ACT_IDENT,
    ACT_RELU
  } act_mode_e;

  typedef enum logic {
    EMPTY,
    DRAIN
  } drain_e;

  function automatic int acc_width(int bit_size, int in_size);
    return 2 * bit_size + $clog2(in_size + 1) + 1;
  endfunction

endpackage

// File: rtl/layer_quant_act.sv
// Per-neuron shift, clamp and activation of one accumulator.
import layer_pkg::*;

module layer_quant_act #(
  parameter int ACC_W     = 19,
  parameter int BIT_SIZE  = 8,
  parameter int FRAC_BITS = 0,
  parameter int ACT_MODE  = 1
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [BIT_SIZE-1:0] y,
  output logic                       sat_flag
);

  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'((2 ** (BIT_SIZE - 1)) - 1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  localparam bit RELU = (ACT_MODE == int'(ACT_RELU));

  logic signed [ACC_W-1:0] t;

  assign t = acc >>> FRAC_BITS;

  always_comb begin
    y        = t[BIT_SIZE-1:0];
    sat_flag = 1'b0;
    if (t > HI) begin
      y        = HI[BIT_SIZE-1:0];
      sat_flag = 1'b1;
    end else if (t < LO) begin
      y        = LO[BIT_SIZE-1:0];
      sat_flag = 1'b1;
    end
    // a clamped negative that ReLU zeroes is not a saturation
    if (RELU && t < 0) begin
      y        = '0;
      sat_flag = 1'b0;
    end
  end

endmodule

// File: rtl/layer_stream.sv
// Streaming fully connected layer: parallel MACs, double-buffered output.
import layer_pkg::*;

module layer_stream #(
  parameter int IN_SIZE   = 3,
  parameter int OUT_SIZE  = 3,
  parameter int BIT_SIZE  = 8,
  parameter int FRAC_BITS = 0,
  parameter int ACT_MODE  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [BIT_SIZE-1:0]   x,
  input  logic [OUT_SIZE*BIT_SIZE-1:0] w,
  input  logic [OUT_SIZE*BIT_SIZE-1:0] b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [BIT_SIZE-1:0]   y,
  output logic                         out_last,
  output logic                         sat
);

  localparam int ACC_W = acc_width(BIT_SIZE, IN_SIZE);
  localparam int ICW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OCW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [ICW-1:0] IN_LAST = ICW'(IN_SIZE - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_SIZE - 1);

  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  drain_e         state;
  logic           load;
  logic           in_last;
  logic           in_hs;
  logic           out_hs;
  logic           fin_hs;

  logic signed [ACC_W-1:0]    acc     [OUT_SIZE];
  logic signed [ACC_W-1:0]    acc_nxt [OUT_SIZE];
  logic signed [BIT_SIZE-1:0] ybuf    [OUT_SIZE];
  logic signed [BIT_SIZE-1:0] qy      [OUT_SIZE];
  logic [OUT_SIZE-1:0]        qsat;

  assign in_last = (in_cnt == IN_LAST);
  assign out_hs  = out_valid && out_ready;
  assign fin_hs  = out_hs && out_last;
  // a pending load also occupies the buffer (matters when IN_SIZE=1)
  assign in_ready = !(in_last &&
                      (load || (state == DRAIN && !fin_hs)));
  assign in_hs   = in_valid && in_ready;
  assign y       = ybuf[out_cnt];

  for (genvar i = 0; i < OUT_SIZE; i++) begin : g_neuron
    logic signed [BIT_SIZE-1:0]   wi;
    logic signed [BIT_SIZE-1:0]   bi;
    logic signed [2*BIT_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]      base;

    assign wi   = w[i*BIT_SIZE +: BIT_SIZE];
    assign bi   = b[i*BIT_SIZE +: BIT_SIZE];
    assign prod = x * wi;
    assign base = (in_cnt == '0)
                ? {{(ACC_W-BIT_SIZE){bi[BIT_SIZE-1]}}, bi}
                : acc[i];
    assign acc_nxt[i] = base +
      {{(ACC_W-2*BIT_SIZE){prod[2*BIT_SIZE-1]}}, prod};

    layer_quant_act #(
      .ACC_W     (ACC_W),
      .BIT_SIZE  (BIT_SIZE),
      .FRAC_BITS (FRAC_BITS),
      .ACT_MODE  (ACT_MODE)
    ) u_qa (
      .acc      (acc[i]),
      .y        (qy[i]),
      .sat_flag (qsat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
      load   <= 1'b0;
      for (int k = 0; k < OUT_SIZE; k++) acc[k] <= '0;
    end else begin
      load <= in_hs && in_last;
      if (in_hs) begin
        in_cnt <= in_last ? '0 : in_cnt + 1'b1;
        for (int k = 0; k < OUT_SIZE; k++) acc[k] <= acc_nxt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_cnt   <= '0;
      sat       <= 1'b0;
      for (int k = 0; k < OUT_SIZE; k++) ybuf[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < OUT_SIZE; k++) ybuf[k] <= qy[k];
      state     <= DRAIN;
      out_valid <= 1'b1;
      out_cnt   <= '0;
      out_last  <= (OUT_SIZE == 1);
      sat       <= sat | (|qsat);
    end else if (out_hs) begin
      if (out_last) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_cnt   <= '0;
      end else begin
        out_cnt  <= out_cnt + 1'b1;
        out_last <= (out_cnt + 1'b1 == OUT_LAST);
      end
    end
  end

endmodule

// File: tb/tb_layer_stream.sv
// Directed bench: ReLU, identity and FRAC=2 layers share one input stream.
module tb_layer_stream;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic signed [7:0] x;
  logic [15:0]       w;
  logic [15:0]       b;

  logic              in_ready_a, out_valid_a, out_last_a, sat_a;
  logic              in_ready_b, out_valid_b, out_last_b, sat_b;
  logic              in_ready_c, out_valid_c, out_last_c, sat_c;
  logic signed [7:0] y_a, y_b, y_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  layer_stream #(
    .IN_SIZE(3), .OUT_SIZE(2), .BIT_SIZE(8),
    .FRAC_BITS(0), .ACT_MODE(1)
  ) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready_a), .x(x), .w(w), .b(b),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .y(y_a), .out_last(out_last_a), .sat(sat_a)
  );

  layer_stream #(
    .IN_SIZE(3), .OUT_SIZE(2), .BIT_SIZE(8),
    .FRAC_BITS(0), .ACT_MODE(0)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready_b), .x(x), .w(w), .b(b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .y(y_b), .out_last(out_last_b), .sat(sat_b)
  );

  layer_stream #(
    .IN_SIZE(3), .OUT_SIZE(2), .BIT_SIZE(8),
    .FRAC_BITS(2), .ACT_MODE(0)
  ) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready_c), .x(x), .w(w), .b(b),
    .out_valid(out_valid_c), .out_ready(out_ready),
    .y(y_c), .out_last(out_last_c), .sat(sat_c)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int xv, input int w0, input int w1,
                      input int b0, input int b1);
    int   n;
    logic ok;
    x = 8'(xv);
    w = {8'(w1), 8'(w0)};
    b = {8'(b1), 8'(b0)};
    in_valid = 1'b1;
    #1;
    n  = 0;
    ok = in_ready_a;
    while (!ok && n < 50) begin
      @(negedge clk);
      #1;
      ok = in_ready_a;
      n++;
    end
    if (!ok) chk("beat_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int b0, input int b1,
                          input int x0, input int x1, input int x2,
                          input int w0, input int w1);
    beat(x0, w0, w1, b0, b1);
    beat(x1, w0, w1, b0, b1);
    beat(x2, w0, w1, b0, b1);
  endtask

  task automatic get_out(input string tag, input int ea,
                         input int eb, input int ec, input logic el);
    int n;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!out_valid_a && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, out_valid_a, 1);
    chk({tag, "_ya"}, y_a, ea);
    chk({tag, "_yb"}, y_b, eb);
    chk({tag, "_yc"}, y_c, ec);
    chk({tag, "_last"}, out_last_a, el);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; w = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_sat", sat_a, 0);

    // basic vector and load latency
    send_vec(0, 0, 1, 2, 3, 1, -1);
    #1;
    chk("lat_n", out_valid_a, 0);
    @(negedge clk);
    #1;
    chk("lat_n1", out_valid_a, 1);
    get_out("v1n0", 6, 6, 1, 0);
    get_out("v1n1", 0, -6, -2, 1);
    chk("v1_sat", sat_b, 0);
    chk("v1_idle", out_valid_a, 0);

    // nonzero bias on neuron 1
    send_vec(0, 2, 1, 2, 3, 1, -1);
    get_out("v2n0", 6, 6, 1, 0);
    get_out("v2n1", 0, -4, -1, 1);

    // acc=-7 and +7 through shift and ReLU
    send_vec(-7, 7, 0, 0, 0, 1, 1);
    get_out("frn0", 0, -7, -2, 0);
    get_out("frn1", 7, 7, 1, 1);

    // saturation, then sticky flag
    send_vec(0, 0, 100, 100, 100, 2, -2);
    get_out("stn0", 127, 127, 127, 0);
    get_out("stn1", 0, -128, -128, 1);
    chk("st_sat_a", sat_a, 1);
    chk("st_sat_b", sat_b, 1);
    chk("st_sat_c", sat_c, 1);
    send_vec(0, 0, 1, 2, 3, 1, -1);
    get_out("skn0", 6, 6, 1, 0);
    get_out("skn1", 0, -6, -2, 1);
    chk("sticky_sat", sat_b, 1);

    // backpressure with overlapped second vector
    send_vec(0, 0, 1, 2, 3, 1, -1);
    beat(1, 1, -1, 0, 2);
    beat(2, 1, -1, 0, 2);
    x = 8'sd3; w = {8'hff, 8'h01}; b = {8'd2, 8'd0};
    in_valid = 1'b1;
    #1;
    chk("bp_stall", in_ready_a, 0);
    @(negedge clk);
    #1;
    chk("bp_stall2", in_ready_a, 0);
    chk("bp_hold_v", out_valid_a, 1);
    chk("bp_hold_y", y_b, 6);
    out_ready = 1'b1;
    #1;
    chk("bp_first_rdy", in_ready_a, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_y1", y_b, -6);
    chk("bp_last", out_last_a, 1);
    chk("bp_rdy_on_last", in_ready_a, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    get_out("bp2n0", 6, 6, 1, 0);
    get_out("bp2n1", 0, -4, -1, 1);

    // reset mid-vector
    beat(100, 2, -2, 50, 50);
    beat(100, 2, -2, 50, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmv_valid", out_valid_a, 0);
    chk("rmv_ready", in_ready_a, 1);
    chk("rmv_sat", sat_b, 0);
    send_vec(0, 0, 1, 2, 3, 1, -1);
    get_out("rmn0", 6, 6, 1, 0);

    // reset mid-drain
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmd_valid", out_valid_a, 0);
    chk("rmd_y", y_b, 0);
    @(negedge clk);
    #1;
    chk("rmd_valid2", out_valid_a, 0);
    send_vec(5, -3, 0, 0, 0, 1, 1);
    get_out("frsn0", 5, 5, 1, 0);
    get_out("frsn1", 0, -3, -1, 1);
    chk("frs_sat", sat_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_stream.md
Name: layer_stream

Overview:
- Fully connected NN layer with OUT_SIZE neurons, parallel MACs, fed one input element per beat over a valid/ready stream.
- Each neuron has a signed accumulator preloaded with a bias. Results are quantised, saturated and activated, then streamed out one neuron per beat.
- A double-buffered output stage lets the next input vector accumulate while the previous result drains.
- Layers chain directly: y/out_valid/out_ready of one instance feed x/in_valid/in_ready of the next.

Parameters:
- IN_SIZE, 3, input elements per vector (beats per accumulation), >=1
- OUT_SIZE, 3, neurons per layer (output beats per vector), >=1
- BIT_SIZE, 8, signed width of x, w, b, y
- FRAC_BITS, 0, arithmetic right shift applied to the accumulator before saturation, 0..BIT_SIZE
- ACT_MODE, 1, 0 = identity (saturate only), 1 = ReLU
- ACC_W (localparam), 2*BIT_SIZE+$clog2(IN_SIZE+1)+1, accumulator width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  x/w beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- x  in  BIT_SIZE  signed input element
- w  in  OUT_SIZE*BIT_SIZE  signed weight of each neuron for the current element (w[i] for neuron i)
- b  in  OUT_SIZE*BIT_SIZE  signed biases, sampled on the first beat of each vector
- out_valid  out  1  y valid
- out_ready  in  1  downstream accepts y
- y  out  BIT_SIZE  activated output, neuron 0 first
- out_last  out  1  high with the neuron OUT_SIZE-1 beat
- sat  out  1  sticky: some output saturated since reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset values: in_ready=1, out_valid=0, out_last=0, y=0, sat=0. Reset also clears in_cnt, out_cnt, accumulators and buffer flag.
- Reset mid-vector or mid-drain discards all partial state. There is no output after reset until a full new vector has been accepted.
- Accumulate side, counter in_cnt 0..IN_SIZE-1:
  - On a handshake with in_cnt==0: acc[i] <= sext(b[i]) + x*w[i].
  - On other handshakes: acc[i] <= acc[i] + x*w[i].
  - Products are full 2*BIT_SIZE signed; accumulation never overflows ACC_W.
  - On the handshake with in_cnt==IN_SIZE-1, in_cnt wraps to 0 and load fires.
- Post-process per neuron (combinational, sub-module):
  - t = acc >>> FRAC_BITS.
  - Clamp t to [-2^(BIT_SIZE-1), 2^(BIT_SIZE-1)-1]; flag when clamped.
  - ReLU mode: negative results become 0. The ReLU-zeroed case does not count as saturation.
- Load: cycle after the last input handshake, ybuf[i] <= act(acc[i]) for all i.
  - Sets buf_full, out_cnt=0, out_valid=1.
  - sat |= OR of that vector's clamp flags.
  - Latency: last input beat accepted at edge N -> out_valid=1 with y=neuron 0 after edge N+1.
- Drain states: EMPTY (out_valid=0) and DRAIN (out_valid=1).
  - y = ybuf[out_cnt].
  - On out_valid&&out_ready, out_cnt++.
  - On the handshake with out_cnt==OUT_SIZE-1 (out_last=1), buf_full clears, unless a load fires the same cycle. In that case buf_full stays 1 and out_cnt=0 with the new data.
  - y/out_valid are held stable while out_ready=0.
- Overlap and backpressure:
  - in_ready = !(in_cnt==IN_SIZE-1 && buf_full && !final_drain_hs).
  - final_drain_hs = out_valid&&out_ready&&out_last.
  - Only the last beat of a vector stalls. The combinational path out_ready->in_ready is allowed.
  - Because load happens the cycle after the final input handshake, that handshake only occurs when the buffer is free or freeing.
- Edge cases:
  - IN_SIZE=1: every beat is both first and last.
  - OUT_SIZE=1: out_last is constant 1 while out_valid.
- in_valid low between beats leaves state unchanged. Weights/biases are only sampled on handshakes.

Decomposition:
- Package layer_pkg holds:
  - act_mode_e (ACT_IDENT, ACT_RELU)
  - drain state enum (EMPTY, DRAIN)
  - function acc_width(bit_size, in_size)
- Sub-module layer_quant_act #(ACC_W, BIT_SIZE, FRAC_BITS, ACT_MODE): acc in, y and sat_flag out, purely combinational. Instantiate OUT_SIZE copies in a generate loop.
- MAC update stays in the top-level generate loop.

Test Plan:
- IN=3, OUT=2, BIT=8, FRAC=0, ReLU, b=0; x=1,2,3; w0=1,1,1; w1=-1,-1,-1 -> y=6 then 0, out_last on 2nd beat, out_valid rises one cycle after 3rd input handshake, sat=0.
- Same config, identity mode, b1=2 -> y=6 then -4.
- Saturation: x=100,100,100, w0=2, w1=-2, identity -> y=127 then -128, sat=1 and stays 1 through later unsaturated vectors until rst.
- Backpressure/overlap: out_ready=0; send 2 vectors back to back -> first 2 beats of vector 2 accepted, in_ready=0 on its 3rd beat. Then raise out_ready -> in_ready rises in the same cycle as the out_last handshake, and vector 2 outputs follow with no gap.
- FRAC=2: acc=-7 -> y=-2 (arithmetic shift), ReLU -> 0.
- Reset mid-vector (after 2 beats) and mid-drain (after 1 output) -> out_valid=0 next cycle. The next full vector produces outputs computed from fresh biases only.
